// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and address-width helper.
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: producer/consumer handshake and occupancy status of the FIFO.
interface ram_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = aw_of(DEPTH);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, full, empty
  );
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, full, empty
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: storage array with synchronous write and asynchronous read; contents are never reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [2**AW];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: pointer, occupancy and handshake control around fifo_mem.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic            clk,
  input logic            rst,
  ram_fifo_ctrl_if.slave bus
);
  localparam int AW = aw_of(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  // Status comes from the registered count so full and empty stay distinguishable.
  assign bus.full     = count_q == (AW+1)'(DEPTH);
  assign bus.empty    = count_q == '0;
  assign bus.wr_ready = !bus.full;
  assign bus.rd_valid = !bus.empty;
  assign bus.count    = count_q;
  always_comb begin
    push     = bus.wr_valid && bus.wr_ready;
    pop      = bus.rd_valid && bus.rd_ready;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  fifo_mem #(.WIDTH(WIDTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(bus.wr_data),
    .raddr(rd_ptr_q),
    .rdata(bus.rd_data)
  );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: queue-model scoreboard bench for ram_fifo_ctrl with directed and random traffic.
module tb_ram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [WIDTH-1:0] exp_q [$];
  ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_status(input string tag);
    chk({tag, " count"}, int'(bus.count), mcount);
    chk({tag, " full"}, int'(bus.full), int'(mcount == DEPTH));
    chk({tag, " empty"}, int'(bus.empty), int'(mcount == 0));
    chk({tag, " wr_ready"}, int'(bus.wr_ready), int'(mcount != DEPTH));
    chk({tag, " rd_valid"}, int'(bus.rd_valid), int'(mcount != 0));
  endtask
  // Drive one cycle; the model decides acceptance from occupancy alone.
  task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
    bit p, q;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    p = wv && mcount < DEPTH;
    q = rr && mcount > 0;
    if (p) exp_q.push_back(wd);
    @(posedge clk);
    #1;
    mcount = mcount + int'(p) - int'(q);
  endtask
  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mcount > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("drained", mcount, 0);
    chk("scoreboard empty", exp_q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk_status("mon");
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop: DUT popped %0h with nothing expected", bus.rd_data);
        end else chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    #2;
    chk_status("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(8'h20 + 8 * i), 1'b0);
    chk("after 8 pushes count", int'(bus.count), 8);
    chk("after 8 pushes full", int'(bus.full), 1);
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'hE0 + i), 1'b0);
    chk("held write ignored", int'(bus.count), 8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    chk("after 8 pops empty", int'(bus.empty), 1);
    chk("after 8 pops count", int'(bus.count), 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(8'h70 + i), 1'b0);
    drain();
    for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'($urandom), 1'b1);
    chk("streaming count", int'(bus.count), 3);
    drain();
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'($urandom), 1'b0);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async reset count", int'(bus.count), 0);
    chk("async reset empty", int'(bus.empty), 1);
    chk("async reset rd_valid", int'(bus.rd_valid), 0);
    exp_q.delete();
    mcount = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 8'hA5, 1'b0);
    chk("A5 rd_valid", int'(bus.rd_valid), 1);
    chk("A5 rd_data", int'(bus.rd_data), 8'hA5);
    drain();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 8: entry count, power of two; AW = log2(DEPTH) (3 at default).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 wr_valid  input  1  producer offers wr_data this cycle.
REQ-007 wr_ready  output  1  FIFO accepts a write this cycle.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_valid  output  1  rd_data holds the oldest entry.
REQ-010 rd_ready  input  1  consumer takes rd_data this cycle.
REQ-011 rd_data  output  WIDTH  oldest stored entry.
REQ-012 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.

Function
REQ-015 Push SHALL occur on a rising clk edge when wr_valid && wr_ready; wr_data is written to mem[wr_ptr], and wr_ptr increments.
REQ-016 Pop SHALL occur on a rising clk edge when rd_valid && rd_ready; rd_ptr increments.
REQ-017 wr_ready SHALL equal !full, combinationally; there is no write-through when full, even with a simultaneous pop.
REQ-018 rd_valid SHALL equal !empty, combinationally.
REQ-019 rd_data SHALL be the combinational read of mem[rd_ptr], giving zero cycles from rd_ptr update to data.
REQ-020 rd_data SHALL be undefined (don't-care) while empty.
REQ-021 Latency: a word pushed at edge N SHALL appear on rd_data with rd_valid=1 after edge N when the FIFO was empty.
REQ-022 Pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0 with no extra state.
REQ-023 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 full and empty SHALL be derived from registered count, never from pointer equality alone.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH SHALL both proceed in the same cycle.
REQ-026 A push SHALL be accepted when empty, while pop is blocked that cycle because rd_valid=0.
REQ-027 A pop SHALL be accepted when full, while push is blocked that cycle because wr_ready=0.
REQ-028 The producer MAY hold wr_valid with changing wr_data while wr_ready=0; no state changes.

Reset
REQ-029 While rst=1, wr_ptr, rd_ptr and count SHALL be 0; full=0, empty=1, wr_ready=1, rd_valid=0.
REQ-030 Reset assertion mid-operation SHALL discard all stored entries immediately, without waiting for a clk edge.
REQ-031 Memory array contents SHALL NOT be reset.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 Package fifo_pkg SHALL hold the WIDTH/DEPTH defaults and the AW computation.
REQ-034 Storage SHALL be one sub-module, fifo_mem, with a synchronous write port (clk, we, waddr, wdata) and an asynchronous read port (raddr, rdata).
REQ-035 ram_fifo_ctrl SHALL hold the pointers, count and handshake logic only.

Verification
REQ-036 Reset then 8 pushes of 0x20,0x28,...,0x58 with rd_ready=0 -> count=8, full=1, wr_ready=0; the 9th write with wr_valid=1 is ignored.
REQ-037 From full, 8 pops -> rd_data sequence 0x20..0x58 in order; then empty=1, rd_valid=0, count=0.
REQ-038 Push 5, pop 5, push 6 -> pointers wrap past 7; the 6 reads return the last 6 written values in order.
REQ-039 With count=3, hold wr_valid=1 and rd_ready=1 for 10 cycles -> count stays 3 and the output stream equals the input stream delayed by 3 entries.
REQ-040 Assert rst between edges with count=5 -> count=0 and empty=1 immediately; after release, push 0xA5 -> rd_data=0xA5 with rd_valid=1 after one edge.
